// File: rtl/parking_pkg.sv
// Shared types and sensor pattern constants for the parking-lot occupancy controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    CLR
  } lane_state_t;

  // Patterns are {B, A}: B is the inner beam, A the outer beam.
  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_A    = 2'b01;
  localparam logic [1:0] P_AB   = 2'b11;
  localparam logic [1:0] P_B    = 2'b10;

endpackage

// File: rtl/parking_lot_ctrl_lane_fsm.sv
// Per-lane sensor synchronizer and entry/exit sequence decoder with registered pulses.
module lane_fsm
  import parking_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] Sensor,
  output logic       Enter,
  output logic       Exit
);

  logic [1:0]  sync1;
  logic [1:0]  sync2;
  lane_state_t state;

  // A pattern equal to the previous step steps back one state; anything unexpected parks in CLR.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      state <= IDLE;
      Enter <= 1'b0;
      Exit  <= 1'b0;
    end else begin
      sync1 <= Sensor;
      sync2 <= sync1;
      Enter <= 1'b0;
      Exit  <= 1'b0;
      case (state)
        IDLE: begin
          case (sync2)
            P_NONE:  state <= IDLE;
            P_A:     state <= EN1;
            P_B:     state <= EX1;
            default: state <= CLR;
          endcase
        end
        EN1: begin
          case (sync2)
            P_A:     state <= EN1;
            P_AB:    state <= EN2;
            P_NONE:  state <= IDLE;
            default: state <= CLR;
          endcase
        end
        EN2: begin
          case (sync2)
            P_AB:    state <= EN2;
            P_B:     state <= EN3;
            P_A:     state <= EN1;
            default: state <= CLR;
          endcase
        end
        EN3: begin
          case (sync2)
            P_B:     state <= EN3;
            P_AB:    state <= EN2;
            P_NONE: begin
              state <= IDLE;
              Enter <= 1'b1;
            end
            default: state <= CLR;
          endcase
        end
        EX1: begin
          case (sync2)
            P_B:     state <= EX1;
            P_AB:    state <= EX2;
            P_NONE:  state <= IDLE;
            default: state <= CLR;
          endcase
        end
        EX2: begin
          case (sync2)
            P_AB:    state <= EX2;
            P_A:     state <= EX3;
            P_B:     state <= EX1;
            default: state <= CLR;
          endcase
        end
        EX3: begin
          case (sync2)
            P_A:     state <= EX3;
            P_AB:    state <= EX2;
            P_NONE: begin
              state <= IDLE;
              Exit  <= 1'b1;
            end
            default: state <= CLR;
          endcase
        end
        default: begin
          if (sync2 == P_NONE) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// N-lane parking-lot controller: per-lane decoders feeding one saturating occupancy counter.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter  int LANES    = 2,
  parameter  int CAPACITY = 25,
  localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [2*LANES-1:0]   Sensor,
  output logic [LANES-1:0]     Enter,
  output logic [LANES-1:0]     Exit,
  output logic [CNT_W-1:0]     Count,
  output logic                 Full,
  output logic                 Empty,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int AW = CNT_W + 4;

  for (genvar i = 0; i < LANES; i++) begin : lanes
    lane_fsm u_lane (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Sensor (Sensor[2*i+1:2*i]),
      .Enter  (Enter[i]),
      .Exit   (Exit[i])
    );
  end

  logic [AW-1:0]    e_cnt;
  logic [AW-1:0]    x_cnt;
  logic [AW-1:0]    cnt_ext;
  logic [AW-1:0]    x_eff;
  logic [AW-1:0]    room;
  logic [AW-1:0]    e_eff;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  // Exits free space before entries claim it, so a same-cycle swap at full capacity nets to zero.
  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      e_cnt = e_cnt + AW'(Enter[i]);
      x_cnt = x_cnt + AW'(Exit[i]);
    end
    cnt_ext   = AW'(Count);
    unf_nxt   = (x_cnt > cnt_ext);
    x_eff     = unf_nxt ? cnt_ext : x_cnt;
    room      = AW'(CAPACITY) - cnt_ext + x_eff;
    ovf_nxt   = (e_cnt > room);
    e_eff     = ovf_nxt ? room : e_cnt;
    count_nxt = CNT_W'(cnt_ext - x_eff + e_eff);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Count     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Count     <= count_nxt;
      Overflow  <= ovf_nxt;
      Underflow <= unf_nxt;
    end
  end

  assign Full  = (Count == CNT_W'(CAPACITY));
  assign Empty = (Count == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench: a default 25-space lot and a 3-space lot, both with two lanes.
module tb_parking_lot_ctrl;
  import parking_pkg::*;

  typedef struct {
    logic [1:0] enter;
    logic [1:0] exit;
    int         count;
    logic       ovf;
    logic       unf;
  } exp_t;

  localparam logic [7:0] ENTRY_SEQ = {P_A, P_AB, P_B, P_NONE};
  localparam logic [7:0] EXIT_SEQ  = {P_B, P_AB, P_A, P_NONE};
  localparam logic [7:0] REV_SEQ   = {P_A, P_AB, P_A, P_NONE};
  localparam logic [7:0] BAD_SEQ   = {P_NONE, P_AB, P_B, P_NONE};
  localparam logic [7:0] QUIET_SEQ = {P_NONE, P_NONE, P_NONE, P_NONE};

  logic       clk;
  logic       rst_n;
  logic [3:0] sensor_b, sensor_s;
  logic [1:0] enter_b, exit_b, enter_s, exit_s;
  logic [4:0] count_b;
  logic [1:0] count_s;
  logic       full_b, empty_b, ovf_b, unf_b;
  logic       full_s, empty_s, ovf_s, unf_s;

  int   compared   = 0;
  int   mismatched = 0;
  int   mc[2]      = '{0, 0};
  int   cap[2]     = '{25, 3};
  exp_t q_b[$];
  exp_t q_s[$];
  exp_t pend_b, pend_s;
  bit   has_pend_b = 0;
  bit   has_pend_s = 0;

  parking_lot_ctrl #(.LANES(2), .CAPACITY(25)) dut (
    .Clk(clk), .Rst_n(rst_n), .Sensor(sensor_b), .Enter(enter_b), .Exit(exit_b),
    .Count(count_b), .Full(full_b), .Empty(empty_b), .Overflow(ovf_b), .Underflow(unf_b)
  );

  parking_lot_ctrl #(.LANES(2), .CAPACITY(3)) dut_small (
    .Clk(clk), .Rst_n(rst_n), .Sensor(sensor_s), .Enter(enter_s), .Exit(exit_s),
    .Count(count_s), .Full(full_s), .Empty(empty_s), .Overflow(ovf_s), .Underflow(unf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int inst, input logic [3:0] sens, input int cycles);
    if (inst == 0) sensor_b = sens;
    else sensor_s = sens;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic run_steps(input int inst, input logic [7:0] p0, input logic [7:0] p1);
    for (int k = 0; k < 4; k++)
      apply_stimulus(inst, {p1[7-2*k -: 2], p0[7-2*k -: 2]}, 4);
  endtask

  // Expected occupancy arithmetic: exits first, then entries up to the remaining room.
  task automatic push_exp(input int inst, input logic [1:0] en, input logic [1:0] ex);
    exp_t e;
    int   ne, nx, xe, room;
    ne = $countones(en);
    nx = $countones(ex);
    e.enter = en;
    e.exit  = ex;
    e.unf   = (nx > mc[inst]);
    xe      = e.unf ? mc[inst] : nx;
    room    = cap[inst] - mc[inst] + xe;
    e.ovf   = (ne > room);
    mc[inst] = mc[inst] - xe + (e.ovf ? room : ne);
    e.count = mc[inst];
    if (inst == 0) q_b.push_back(e);
    else q_s.push_back(e);
  endtask

  task automatic wait_drain(input int inst, input string tag);
    int left;
    for (int c = 0; c < 40; c++) begin
      left = (inst == 0) ? q_b.size() + int'(has_pend_b) : q_s.size() + int'(has_pend_s);
      if (left == 0) break;
      @(negedge clk);
    end
    left = (inst == 0) ? q_b.size() + int'(has_pend_b) : q_s.size() + int'(has_pend_s);
    check_output(tag, left, 0);
  endtask

  always @(negedge clk) begin
    if (has_pend_b) begin
      check_output("big_count", count_b, pend_b.count);
      check_output("big_full", full_b, pend_b.count == 25);
      check_output("big_empty", empty_b, pend_b.count == 0);
      check_output("big_overflow", ovf_b, pend_b.ovf);
      check_output("big_underflow", unf_b, pend_b.unf);
      has_pend_b = 0;
    end
    if (rst_n && (enter_b != 2'b00 || exit_b != 2'b00)) begin
      if (q_b.size() == 0) check_output("big_unexpected_pulse", {enter_b, exit_b}, 0);
      else begin
        pend_b = q_b.pop_front();
        check_output("big_enter", enter_b, pend_b.enter);
        check_output("big_exit", exit_b, pend_b.exit);
        has_pend_b = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (has_pend_s) begin
      check_output("small_count", count_s, pend_s.count);
      check_output("small_full", full_s, pend_s.count == 3);
      check_output("small_empty", empty_s, pend_s.count == 0);
      check_output("small_overflow", ovf_s, pend_s.ovf);
      check_output("small_underflow", unf_s, pend_s.unf);
      has_pend_s = 0;
    end
    if (rst_n && (enter_s != 2'b00 || exit_s != 2'b00)) begin
      if (q_s.size() == 0) check_output("small_unexpected_pulse", {enter_s, exit_s}, 0);
      else begin
        pend_s = q_s.pop_front();
        check_output("small_enter", enter_s, pend_s.enter);
        check_output("small_exit", exit_s, pend_s.exit);
        has_pend_s = 1;
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    sensor_b = '0;
    sensor_s = '0;
    repeat (3) @(negedge clk);
    check_output("rst_count", count_b, 0);
    check_output("rst_empty", empty_b, 1);
    check_output("rst_full", full_b, 0);
    check_output("rst_pulses", {enter_b, exit_b, ovf_b, unf_b}, 0);
    check_output("rst_small_count", count_s, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] lane 0 entry then exit");
    push_exp(0, 2'b01, 2'b00);
    run_steps(0, ENTRY_SEQ, QUIET_SEQ);
    wait_drain(0, "drain_entry0");
    push_exp(0, 2'b00, 2'b01);
    run_steps(0, EXIT_SEQ, QUIET_SEQ);
    wait_drain(0, "drain_exit0");

    $display("[TB] reversal on lane 0");
    run_steps(0, REV_SEQ, QUIET_SEQ);
    repeat (4) @(negedge clk);
    check_output("rev_count", count_b, mc[0]);
    check_output("rev_state", 32'(dut.lanes[0].u_lane.state), 32'(IDLE));

    $display("[TB] illegal pattern on lane 1, then valid entry");
    run_steps(0, QUIET_SEQ, BAD_SEQ);
    repeat (4) @(negedge clk);
    check_output("bad_count", count_b, mc[0]);
    push_exp(0, 2'b10, 2'b00);
    run_steps(0, QUIET_SEQ, ENTRY_SEQ);
    wait_drain(0, "drain_entry1");

    $display("[TB] fill to 5, then simultaneous entry and exit");
    for (int n = 0; n < 4; n++) begin
      push_exp(0, 2'b01, 2'b00);
      run_steps(0, ENTRY_SEQ, QUIET_SEQ);
    end
    wait_drain(0, "drain_fill");
    check_output("fill_count", count_b, 5);
    push_exp(0, 2'b01, 2'b10);
    run_steps(0, ENTRY_SEQ, EXIT_SEQ);
    wait_drain(0, "drain_simul");

    $display("[TB] small lot capacity and underflow");
    for (int n = 0; n < 4; n++) begin
      push_exp(1, 2'b01, 2'b00);
      run_steps(1, ENTRY_SEQ, QUIET_SEQ);
    end
    wait_drain(1, "drain_small_fill");
    check_output("small_full_hold", full_s, 1);
    for (int n = 0; n < 4; n++) begin
      push_exp(1, 2'b00, 2'b10);
      run_steps(1, QUIET_SEQ, EXIT_SEQ);
    end
    wait_drain(1, "drain_small_empty");
    check_output("small_empty_hold", empty_s, 1);

    $display("[TB] reset in the middle of an entry");
    apply_stimulus(0, {P_NONE, P_A}, 4);
    apply_stimulus(0, {P_NONE, P_AB}, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrst_count", count_b, 0);
    check_output("midrst_empty", empty_b, 1);
    check_output("midrst_pulses", {enter_b, exit_b, ovf_b, unf_b}, 0);
    mc[0] = 0;
    mc[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, {P_NONE, P_B}, 4);
    apply_stimulus(0, {P_NONE, P_NONE}, 8);
    check_output("midrst_after_count", count_b, 0);
    wait_drain(0, "drain_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Multi-lane parking-lot occupancy controller. Each lane has an outer (A) and inner (B) photo-sensor pair. A per-lane state machine decodes complete entry and exit sequences, tolerates cars reversing, and ignores illegal patterns. A shared saturating counter tracks occupancy against a capacity limit. The block sits between the board sensor inputs and the display/LED top level, replacing the single-lane sensor block with a parametrised N-lane version.

## Interface
Parameters:
- LANES, 2, number of lanes (1–8)
- CAPACITY, 25, maximum occupancy (1–255)
- CNT_W, $clog2(CAPACITY+1), derived localparam; width of Count

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous, active-low reset
- Sensor  in  2*LANES  raw sensor bits, 1 = beam blocked; Sensor[2i] = lane i A (outer), Sensor[2i+1] = lane i B (inner)
- Enter  out  LANES  one-cycle pulse per completed entry, per lane
- Exit  out  LANES  one-cycle pulse per completed exit, per lane
- Count  out  CNT_W  current occupancy
- Full  out  1  Count == CAPACITY
- Empty  out  1  Count == 0
- Overflow  out  1  one-cycle pulse: at least one entry not counted because lot full
- Underflow  out  1  one-cycle pulse: at least one exit not counted because count zero

## Operation
- Every Sensor bit passes through a 2-flop synchronizer. The FSMs see only synchronized values; below, {B,A} means synchronized bits.
- Per-lane FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, CLR.
- Entry path: IDLE -01-> EN1 -11-> EN2 -10-> EN3 -00-> IDLE, asserting Enter[i].
- Exit path: IDLE -10-> EX1 -11-> EX2 -01-> EX3 -00-> IDLE, asserting Exit[i].
- Unchanged input: stay in the current state.
- Reversal: input equal to the previous step's pattern returns to the previous state, with no pulse.
  - EN1 on 00 → IDLE (aborted entry).
  - EN2 on 01 → EN1; EN3 on 11 → EN2.
  - Exit path is symmetric: EX1 on 00 → IDLE; EX2 on 10 → EX1; EX3 on 11 → EX2.
- Any other pattern (e.g. IDLE on 11, EN1 on 10) → CLR. CLR stays until 00, then → IDLE with no pulse.
- Enter and Exit are never both asserted for the same lane.
- Counter update, once per cycle, from the registered pulses:
  - E = popcount(Enter), X = popcount(Exit).
  - Exits are applied first: X' = min(X, Count). Underflow pulses if X > Count.
  - Entries are applied next: E' = min(E, CAPACITY − Count + X'). Overflow pulses if E > E'.
  - Count ← Count − X' + E'.
  - Internal arithmetic is CNT_W+4 bits wide, so nothing wraps.
- Full and Empty are decoded combinationally from the Count register.

## Timing
- Reset (Rst_n low, asynchronous): all sync flops 0, all FSMs IDLE, Enter/Exit/Overflow/Underflow 0, Count 0, Empty 1, Full 0.
- Reset asserted mid-sequence abandons the sequence; no pulse occurs at or after release.
- Latency, raw input to Enter/Exit: the pulse is high in the cycle following the 3rd rising edge after the raw final 00 is stable (2 sync + 1 FSM register).
- Latency, pulse to Count: Count changes on the edge after the pulse. Full, Empty, Overflow and Underflow align with that Count update.
- Entries and exits on different lanes in the same cycle are netted in that single update; no event is lost or deferred.
- Minimum sensor pattern hold time is 3 Clk cycles. Shorter glitches may be missed and need not be handled.

## Structure
- Package parking_pkg:
  - lane_state_t enum {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, CLR}
  - localparam pattern constants P_NONE = 2'b00, P_A = 2'b01, P_AB = 2'b11, P_B = 2'b10
- Sub-module lane_fsm: one instance per lane via generate.
  - Contains: synchronizer, state register, registered Enter/Exit outputs.
  - Ports: Clk, Rst_n, Sensor[1:0], Enter, Exit.
- The top holds the popcount, the saturating counter and the flag logic.

## Test plan
- Lane 0 single entry (A, AB, B, none, 4 cycles each), then exit (B, AB, A, none) → one Enter[0] pulse, Count 0→1, Empty falls; then one Exit[0] pulse, Count 1→0, Empty rises.
- Reversal: lane 0 A → AB → A → none → no Enter/Exit pulse, Count unchanged, FSM back in IDLE.
- Illegal: lane 1 none → AB → B → none → no pulse. A valid entry that follows → Enter[1] and Count +1.
- Simultaneous: Count = 5; lane 0 entry and lane 1 exit complete on the same cycle → Enter[0] and Exit[1] pulse together, Count stays 5.
- Capacity with CAPACITY = 3, LANES = 2: three entries → Count 3, Full 1. Fourth entry → Enter pulses, Overflow pulses, Count stays 3. From Count 0, one exit → Underflow pulses, Count stays 0.
- Reset mid-sequence: lane 0 at EN2 (AB held), Rst_n pulsed low → outputs at reset values, then sensors go B, none → no Enter pulse.
